// File: rtl/fp_round_pipe.sv
// fp_round_pipe
// -------------
// Two-stage rounding and normalisation stage for the floating-point MAC
// datapath. Stage 1 folds the optional overflow bit back into range by a
// single right shift. Stage 2 rounds in one of four IEEE-754 modes, chosen
// per beat, and saturates exponent overflow to infinity or to max-finite.
// Each stage has a valid bit. A stage loads when it is empty or when its
// contents leave in the same cycle, so the block sustains one beat per cycle
// and holds up to two beats under backpressure.
//
// Parameters
//   MAN_W            stored fraction bits
//   EXP_W            biased exponent bits
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   in_valid         input beat present
//   in_ready         block can accept a beat
//   in_sign          sign of value
//   in_exponent      biased exponent
//   in_significand   {overflow, hidden, fraction[MAN_W-1:0], guard}
//   in_sticky        OR of all bits below guard
//   in_mode          00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
//   out_valid        result present
//   out_ready        downstream accepts
//   out_sign         result sign
//   out_exponent     result exponent
//   out_significand  {hidden, fraction}
//   out_inexact      a nonzero bit was discarded
//   out_overflow     result saturated to inf or max-finite

module fp_round_pipe #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exponent,
  input  logic [MAN_W+2:0] in_significand,
  input  logic             in_sticky,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exponent,
  output logic [MAN_W:0]   out_significand,
  output logic             out_inexact,
  output logic             out_overflow
);

  localparam logic [1:0] MODE_RNE = 2'b00;
  localparam logic [1:0] MODE_RTZ = 2'b01;
  localparam logic [1:0] MODE_RUP = 2'b10;
  localparam logic [1:0] MODE_RDN = 2'b11;

  localparam logic [EXP_W-1:0] EXP_ONES    = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAX_FIN = {{(EXP_W-1){1'b1}}, 1'b0};
  // Internal exponents carry one extra bit so that the normalise and carry
  // increments cannot wrap before the saturation check sees them.
  localparam logic [EXP_W:0]   EXP_LIMIT   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   EXP_INC     = {{EXP_W{1'b0}}, 1'b1};

  localparam logic [MAN_W:0]   SIG_INF     = {1'b1, {MAN_W{1'b0}}};
  localparam logic [MAN_W:0]   SIG_MAX_FIN = {(MAN_W+1){1'b1}};

  // Handshake: each stage advances when empty or draining this cycle.
  logic s1_valid;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1 combinational normalise.
  logic             n1_special;
  logic [EXP_W:0]   n1_exp;
  logic [MAN_W:0]   n1_sig;
  logic             n1_guard;
  logic             n1_sticky;

  // An all-ones input exponent marks inf/NaN: the significand is forwarded
  // untouched and guard/sticky are zeroed so nothing downstream rounds it.
  // Otherwise a set overflow bit shifts one place right, the old fraction LSB
  // becomes the new guard and the old guard folds into sticky.
  always_comb begin
    n1_special = (in_exponent == EXP_ONES);
    n1_exp     = {1'b0, in_exponent};
    n1_sig     = in_significand[MAN_W+1:1];
    n1_guard   = in_significand[0];
    n1_sticky  = in_sticky;
    if (n1_special) begin
      n1_guard  = 1'b0;
      n1_sticky = 1'b0;
    end else if (in_significand[MAN_W+2]) begin
      n1_sig    = in_significand[MAN_W+2:2];
      n1_guard  = in_significand[1];
      n1_sticky = in_sticky | in_significand[0];
      n1_exp    = {1'b0, in_exponent} + EXP_INC;
    end
  end

  // Stage 1 registers.
  logic             s1_sign;
  logic [1:0]       s1_mode;
  logic             s1_special;
  logic [EXP_W:0]   s1_exp;
  logic [MAN_W:0]   s1_sig;
  logic             s1_guard;
  logic             s1_sticky;

  // The mode travels with its beat so per-beat mode changes line up with
  // the data they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mode    <= 2'b00;
      s1_special <= 1'b0;
      s1_exp     <= '0;
      s1_sig     <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_mode    <= in_mode;
        s1_special <= n1_special;
        s1_exp     <= n1_exp;
        s1_sig     <= n1_sig;
        s1_guard   <= n1_guard;
        s1_sticky  <= n1_sticky;
      end
    end
  end

  // Stage 2 combinational round and saturate.
  logic             r_inc;
  logic [MAN_W+1:0] r_sum;
  logic             r_carry;
  logic [EXP_W:0]   r_exp;
  logic [MAN_W:0]   r_sig;
  logic             r_to_inf;
  logic [EXP_W-1:0] n2_exp;
  logic [MAN_W:0]   n2_sig;
  logic             n2_inexact;
  logic             n2_overflow;

  // Increment decision per mode; L is the fraction LSB after normalising.
  always_comb begin
    r_inc = 1'b0;
    case (s1_mode)
      MODE_RNE: r_inc = s1_guard & (s1_sig[0] | s1_sticky);
      MODE_RTZ: r_inc = 1'b0;
      MODE_RUP: r_inc = !s1_sign & (s1_guard | s1_sticky);
      MODE_RDN: r_inc =  s1_sign & (s1_guard | s1_sticky);
      default:  r_inc = 1'b0;
    endcase
  end

  // A carry out of the increment can only come from an all-ones significand,
  // so the rounded value is exactly {1, zeros} one binade up.
  always_comb begin
    r_sum   = {1'b0, s1_sig} + {{(MAN_W+1){1'b0}}, r_inc};
    r_carry = r_sum[MAN_W+1];
    r_sig   = r_carry ? SIG_INF : r_sum[MAN_W:0];
    r_exp   = s1_exp + {{EXP_W{1'b0}}, r_carry};
  end

  // Saturation: round-to-nearest always goes to infinity, the directed
  // modes go to infinity only when rounding away from zero, and truncation
  // never does. Specials bypass all of this.
  always_comb begin
    r_to_inf    = 1'b0;
    n2_exp      = r_exp[EXP_W-1:0];
    n2_sig      = r_sig;
    n2_inexact  = s1_guard | s1_sticky;
    n2_overflow = 1'b0;
    case (s1_mode)
      MODE_RNE: r_to_inf = 1'b1;
      MODE_RTZ: r_to_inf = 1'b0;
      MODE_RUP: r_to_inf = !s1_sign;
      MODE_RDN: r_to_inf = s1_sign;
      default:  r_to_inf = 1'b1;
    endcase
    if (s1_special) begin
      n2_exp      = s1_exp[EXP_W-1:0];
      n2_sig      = s1_sig;
      n2_inexact  = 1'b0;
      n2_overflow = 1'b0;
    end else if (r_exp >= EXP_LIMIT) begin
      n2_exp      = r_to_inf ? EXP_ONES : EXP_MAX_FIN;
      n2_sig      = r_to_inf ? SIG_INF  : SIG_MAX_FIN;
      n2_inexact  = 1'b1;
      n2_overflow = 1'b1;
    end
  end

  // Stage 2 registers drive the outputs directly, so out_valid and the data
  // hold their value whenever the stage is not allowed to load.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_sign        <= 1'b0;
      out_exponent    <= '0;
      out_significand <= '0;
      out_inexact     <= 1'b0;
      out_overflow    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign        <= s1_sign;
        out_exponent    <= n2_exp;
        out_significand <= n2_sig;
        out_inexact     <= n2_inexact;
        out_overflow    <= n2_overflow;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe
// ----------------
// Bench for fp_round_pipe at MAN_W=23, EXP_W=8. A monitor records every
// accepted input (turned into an expected result by an arithmetic model of
// the rounding rules) and every delivered output, each stamped with its
// cycle. Scenario tasks drive beats and compare the two records.

module tb_fp_round_pipe;

  localparam int MAN_W = 23;
  localparam int EXP_W = 8;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        inexact;
    logic        overflow;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } entry_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [25:0] in_significand;
  logic        in_sticky;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [23:0] out_significand;
  logic        out_inexact;
  logic        out_overflow;

  int compare_count = 0;
  int fail_count    = 0;
  int cycle         = 0;
  bit rand_done     = 0;

  entry_t exp_q[$];
  entry_t got_q[$];

  fp_round_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sign         (in_sign),
    .in_exponent     (in_exponent),
    .in_significand  (in_significand),
    .in_sticky       (in_sticky),
    .in_mode         (in_mode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sign        (out_sign),
    .out_exponent    (out_exponent),
    .out_significand (out_significand),
    .out_inexact     (out_inexact),
    .out_overflow    (out_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Reference model: keep the bits above the guard as an integer, measure the
  // discarded tail in quarter-ulps (2 = exact half), round by comparing that
  // tail to the half-way point, then saturate by value.
  function automatic res_t model(bit s, logic [7:0] e, logic [25:0] sg, bit st, logic [1:0] m);
    res_t   r;
    longint keep;
    int     rem;
    int     ex;
    bit     up;
    bit     to_inf;
    r.sign = s;
    if (e == 8'hFF) begin
      r.exp = e; r.sig = sg[24:1]; r.inexact = 1'b0; r.overflow = 1'b0;
      return r;
    end
    ex = int'(e);
    if (sg[25]) begin
      keep = longint'(sg) >> 2;
      rem  = 2 * int'(sg[1]) + int'(sg[0] | st);
      ex   = ex + 1;
    end else begin
      keep = longint'(sg) >> 1;
      rem  = 2 * int'(sg[0]) + int'(st);
    end
    case (m)
      2'd0:    up = (rem > 2) || (rem == 2 && (keep % 2) == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && rem > 0;
      default: up = s && rem > 0;
    endcase
    keep = keep + (up ? 1 : 0);
    if (keep >= (longint'(1) << 24)) begin
      keep = keep >> 1;
      ex   = ex + 1;
    end
    if (ex >= 255) begin
      to_inf     = (m == 2'd0) || (m == 2'd2 && !s) || (m == 2'd3 && s);
      r.exp      = to_inf ? 8'hFF : 8'hFE;
      r.sig      = to_inf ? 24'h800000 : 24'hFFFFFF;
      r.inexact  = 1'b1;
      r.overflow = 1'b1;
    end else begin
      r.exp      = 8'(ex);
      r.sig      = 24'(keep);
      r.inexact  = (rem != 0);
      r.overflow = 1'b0;
    end
    return r;
  endfunction

  function automatic entry_t make_entry(res_t r, int c);
    entry_t e;
    e.r   = r;
    e.cyc = c;
    return e;
  endfunction

  // Record accepted inputs and delivered outputs at the falling edge.
  always @(negedge clock) begin
    if (!reset && in_valid && in_ready)
      exp_q.push_back(make_entry(model(in_sign, in_exponent, in_significand, in_sticky, in_mode), cycle));
    if (!reset && out_valid && out_ready)
      got_q.push_back(make_entry({out_sign, out_exponent, out_significand, out_inexact, out_overflow}, cycle));
  end

  function automatic logic [25:0] rand_sig();
    logic [25:0] v;
    v = 26'($urandom);
    if ($urandom_range(0, 15) == 0) v = '0;
    else if ($urandom_range(0, 7) == 0) v[24:1] = 24'hFFFFFF;
    return v;
  endfunction

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 9))
      0:       return 8'hFE;
      1:       return 8'hFF;
      2:       return 8'hFD;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive(bit s, logic [7:0] e, logic [25:0] sg, bit st, logic [1:0] m);
    in_sign        = s;
    in_exponent    = e;
    in_significand = sg;
    in_sticky      = st;
    in_mode        = m;
    in_valid       = 1'b1;
  endtask

  task automatic send_beat(bit s, logic [7:0] e, logic [25:0] sg, bit st, logic [1:0] m);
    int n = 0;
    drive(s, e, sg, st, m);
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      compare_count++;
      fail_count++;
      $display("[TB] FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    compare_count++;
    if (got_q.size() != exp_q.size()) begin
      fail_count++;
      $display("[TB] FAIL drain_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic flush_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    compare_count++;
    if (out_valid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    compare_count++;
    if ({out_sign, out_exponent, out_significand, out_inexact, out_overflow} !== 35'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {out_sign, out_exponent, out_significand, out_inexact, out_overflow});
    end
    compare_count++;
    if (in_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    res_t want;
    flush_queues();
    out_ready = 1'b1;
    send_beat(1'b0, 8'h7F, {1'b0, 1'b1, 23'h7FFFFF, 1'b1}, 1'b0, 2'd0);
    send_beat(1'b0, 8'h10, {1'b1, 1'b0, 23'h000002, 1'b0}, 1'b0, 2'd0);
    send_beat(1'b1, 8'h45, 26'd0, 1'b0, 2'd2);
    send_beat(1'b0, 8'hFF, {1'b0, 1'b1, 23'h400001, 1'b1}, 1'b1, 2'd0);
    send_beat(1'b1, 8'h01, {1'b0, 1'b0, 23'h7FFFFF, 1'b1}, 1'b1, 2'd3);
    wait_drain();
    if (got_q.size() >= 4 && exp_q.size() >= 4) begin
      compare_count++;
      if (got_q[0].cyc - exp_q[0].cyc != 2) begin
        fail_count++;
        $display("[TB] FAIL latency: got %0d cycles required 2", got_q[0].cyc - exp_q[0].cyc);
      end
      want = {1'b0, 8'h80, 24'h800000, 1'b1, 1'b0};
      compare_count++;
      if (got_q[0].r !== want) begin
        fail_count++;
        $display("[TB] FAIL rne_carry: got %h required %h", got_q[0].r, want);
      end
      want = {1'b0, 8'hFF, 24'hC00001, 1'b0, 1'b0};
      compare_count++;
      if (got_q[3].r !== want) begin
        fail_count++;
        $display("[TB] FAIL special_pass: got %h required %h", got_q[3].r, want);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compare_count++;
      if (got_q[i].r !== exp_q[i].r) begin
        fail_count++;
        $display("[TB] FAIL directed[%0d]: got %h required %h", i, got_q[i].r, exp_q[i].r);
      end
    end
  endtask

  task automatic test_modes();
    res_t want;
    flush_queues();
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++)
      send_beat(1'b1, 8'h40, {1'b0, 1'b1, 23'h123454, 1'b1}, 1'b0, 2'(m));
    wait_drain();
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      want = {1'b1, 8'h40, (i == 3) ? 24'h923455 : 24'h923454, 1'b1, 1'b0};
      compare_count++;
      if (got_q[i].r !== want) begin
        fail_count++;
        $display("[TB] FAIL tie_mode[%0d]: got %h required %h", i, got_q[i].r, want);
      end
    end
  endtask

  task automatic test_exp_overflow();
    res_t want;
    flush_queues();
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 4; m++)
        send_beat(1'(s), 8'hFE, {2'b11, 23'($urandom), 1'($urandom)}, 1'($urandom), 2'(m));
    wait_drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (i < 4)
        want = (i == 0 || i == 2) ? {1'b0, 8'hFF, 24'h800000, 1'b1, 1'b1}
                                  : {1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1};
      else
        want = exp_q[i].r;
      compare_count++;
      if (got_q[i].r !== want) begin
        fail_count++;
        $display("[TB] FAIL exp_overflow[%0d]: got %h required %h", i, got_q[i].r, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    flush_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send_beat(1'($urandom), rand_exp(), rand_sig(), 1'($urandom), 2'($urandom));
    wait_drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compare_count++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].cyc != exp_q[i].cyc + 2) begin
        fail_count++;
        $display("[TB] FAIL b2b[%0d]: got %h at +%0d required %h at +2",
                 i, got_q[i].r, got_q[i].cyc - exp_q[i].cyc, exp_q[i].r);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] sgs[4];
    logic [7:0]  es[4];
    logic [1:0]  ms[4];
    bit          ss[4];
    bit          sts[4];
    logic [5:0]  rdy_hist;
    res_t        snap;
    bit          stable;
    int          idx;
    for (int i = 0; i < 4; i++) begin
      sgs[i] = rand_sig(); es[i] = 8'($urandom_range(1, 250));
      ms[i] = 2'($urandom); ss[i] = 1'($urandom); sts[i] = 1'($urandom);
    end
    flush_queues();
    out_ready = 1'b0;
    idx       = 0;
    stable    = 1'b1;
    snap      = '0;
    rdy_hist  = '0;
    drive(ss[0], es[0], sgs[0], sts[0], ms[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      rdy_hist[c] = in_ready;
      if (c == 2) snap = {out_sign, out_exponent, out_significand, out_inexact, out_overflow};
      if (c >= 2 && (!out_valid || {out_sign, out_exponent, out_significand, out_inexact, out_overflow} !== snap))
        stable = 1'b0;
      @(posedge clock);
      #1;
      if (rdy_hist[c] && idx < 4) begin
        idx++;
        if (idx < 4) drive(ss[idx], es[idx], sgs[idx], sts[idx], ms[idx]);
        else in_valid = 1'b0;
      end
    end
    compare_count++;
    if (rdy_hist !== 6'b000011) begin
      fail_count++;
      $display("[TB] FAIL bp_in_ready: got %b required 000011", rdy_hist);
    end
    compare_count++;
    if (exp_q.size() != 2 || got_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL bp_held: got %0d accepted %0d out required 2 accepted 0 out",
               exp_q.size(), got_q.size());
    end
    compare_count++;
    if (!stable) begin
      fail_count++;
      $display("[TB] FAIL bp_stable: got unstable output required stable");
    end
    out_ready = 1'b1;
    for (int i = idx; i < 4; i++)
      send_beat(ss[i], es[i], sgs[i], sts[i], ms[i]);
    wait_drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compare_count++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].cyc != got_q[0].cyc + i) begin
        fail_count++;
        $display("[TB] FAIL bp_release[%0d]: got %h gap %0d required %h gap %0d",
                 i, got_q[i].r, got_q[i].cyc - got_q[0].cyc, exp_q[i].r, i);
      end
    end
  endtask

  task automatic test_random();
    flush_queues();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
          send_beat(1'($urandom), rand_exp(), rand_sig(), 1'($urandom), 2'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compare_count++;
      if (got_q[i].r !== exp_q[i].r) begin
        fail_count++;
        $display("[TB] FAIL random[%0d]: got %h required %h", i, got_q[i].r, exp_q[i].r);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    flush_queues();
    out_ready = 1'b0;
    send_beat(1'b0, 8'h33, rand_sig(), 1'b1, 2'd0);
    send_beat(1'b1, 8'h44, rand_sig(), 1'b0, 2'd3);
    drive(1'b0, 8'h55, rand_sig(), 1'b1, 2'd2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    compare_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL stall_reset_valid: got out_valid=%0b in_ready=%0b required 0/1",
               out_valid, in_ready);
    end
    compare_count++;
    if ({out_sign, out_exponent, out_significand, out_inexact, out_overflow} !== 35'd0) begin
      fail_count++;
      $display("[TB] FAIL stall_reset_outputs: got %h required 0",
               {out_sign, out_exponent, out_significand, out_inexact, out_overflow});
    end
    flush_queues();
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    compare_count++;
    if (got_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL stall_reset_stale: got %0d beats required 0", got_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_sign        = 1'b0;
    in_exponent    = '0;
    in_significand = '0;
    in_sticky      = 1'b0;
    in_mode        = 2'd0;
    out_ready      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_modes();
    test_exp_overflow();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
